// File: rtl/hazard_detection_unit_id.sv
// Hazard detection for the ID stage: finds RAW dependencies that forwarding
// cannot cover (load-use, branch/JR operands needed in ID) and holds the
// front of the pipeline for as many cycles as the dependency requires.
module hazard_detection_unit_id #(
   parameter int NB_ADDR = 5,
   parameter int NB_CNT  = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_enable,
   input  logic [NB_ADDR-1:0] i_rs_id,
   input  logic [NB_ADDR-1:0] i_rt_id,
   input  logic               i_uses_rt_id,
   input  logic               i_branch_id,
   input  logic [NB_ADDR-1:0] i_rd_ex,
   input  logic               i_regWrite_ex,
   input  logic               i_memRead_ex,
   input  logic [NB_ADDR-1:0] i_rd_ex_m,
   input  logic               i_memRead_ex_m,
   output logic               o_stall_pc,
   output logic               o_stall_if_id,
   output logic               o_bubble_id_ex,
   output logic               o_busy,
   output logic [NB_CNT-1:0]  o_stall_cycles
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [1:0]        remaining;
   logic [1:0]        remaining_next;
   logic [1:0]        need_cycles;
   logic              match_ex;
   logic              match_m;
   logic              stall;
   logic [NB_CNT-1:0] stall_cnt;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
      logic [NB_CNT-1:0] one;
      one = {{(NB_CNT-1){1'b0}}, 1'b1};
      return (&v) ? v : v + one;
   endfunction

   // Register-address comparisons; r0 is hardwired and never a dependency.
   always_comb begin
      match_ex = (i_rd_ex != '0) &&
                 ((i_rs_id == i_rd_ex) || (i_uses_rt_id && (i_rt_id == i_rd_ex)));
      match_m  = (i_rd_ex_m != '0) &&
                 ((i_rs_id == i_rd_ex_m) || (i_uses_rt_id && (i_rt_id == i_rd_ex_m)));
   end

   // Number of stall cycles the current ID instruction needs; longest case first.
   always_comb begin
      need_cycles = 2'd0;
      if (i_branch_id && i_memRead_ex && match_ex)
         need_cycles = 2'd2;
      else if (i_memRead_ex && match_ex)
         need_cycles = 2'd1;
      else if (i_branch_id && i_regWrite_ex && match_ex)
         need_cycles = 2'd1;
      else if (i_branch_id && i_memRead_ex_m && match_m)
         need_cycles = 2'd1;
   end

   // Next-state and stall decode: IDLE stalls combinationally on detection,
   // STALL ignores the hazard inputs until the extra cycles are used up.
   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      stall          = 1'b0;
      case (state)
         ST_IDLE: begin
            stall = (need_cycles != 2'd0);
            if (i_enable && (need_cycles == 2'd2)) begin
               state_next     = ST_STALL;
               remaining_next = 2'd1;
            end
         end
         ST_STALL: begin
            stall = 1'b1;
            if (i_enable) begin
               remaining_next = remaining - 2'd1;
               if (remaining <= 2'd1) begin
                  state_next     = ST_IDLE;
                  remaining_next = 2'd0;
               end
            end
         end
         default: begin
            state_next     = ST_IDLE;
            remaining_next = 2'd0;
         end
      endcase
   end

   // State, remaining-cycle count and performance counter; all frozen when disabled.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         remaining <= 2'd0;
         stall_cnt <= '0;
      end else if (i_enable) begin
         state     <= state_next;
         remaining <= remaining_next;
         if (stall)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign o_stall_pc     = stall;
   assign o_stall_if_id  = stall;
   assign o_bubble_id_ex = stall;
   assign o_busy         = (state == ST_STALL);
   assign o_stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_detection_unit_id.sv
// Directed bench for hazard_detection_unit_id with a cycle-level reference model.
module tb_hazard_detection_unit_id;

   localparam int NB_ADDR = 5;
   localparam int NB_CNT  = 4;   // narrow counter so saturation is reachable quickly

   logic               i_clk = 1'b0;
   logic               i_rst_n;
   logic               i_enable;
   logic [NB_ADDR-1:0] i_rs_id;
   logic [NB_ADDR-1:0] i_rt_id;
   logic               i_uses_rt_id;
   logic               i_branch_id;
   logic [NB_ADDR-1:0] i_rd_ex;
   logic               i_regWrite_ex;
   logic               i_memRead_ex;
   logic [NB_ADDR-1:0] i_rd_ex_m;
   logic               i_memRead_ex_m;
   logic               o_stall_pc;
   logic               o_stall_if_id;
   logic               o_bubble_id_ex;
   logic               o_busy;
   logic [NB_CNT-1:0]  o_stall_cycles;

   int n_vec = 0;
   int n_mis = 0;

   // Reference model state: extra forced stall cycles still owed, and counter.
   int  m_left  = 0;
   int  m_cnt   = 0;
   bit  m_valid = 0;

   hazard_detection_unit_id #(.NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_enable       (i_enable),
      .i_rs_id        (i_rs_id),
      .i_rt_id        (i_rt_id),
      .i_uses_rt_id   (i_uses_rt_id),
      .i_branch_id    (i_branch_id),
      .i_rd_ex        (i_rd_ex),
      .i_regWrite_ex  (i_regWrite_ex),
      .i_memRead_ex   (i_memRead_ex),
      .i_rd_ex_m      (i_rd_ex_m),
      .i_memRead_ex_m (i_memRead_ex_m),
      .o_stall_pc     (o_stall_pc),
      .o_stall_if_id  (o_stall_if_id),
      .o_bubble_id_ex (o_bubble_id_ex),
      .o_busy         (o_busy),
      .o_stall_cycles (o_stall_cycles)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Does ID read register r (r0 never counts)?
   function automatic bit reads(input int r);
      if (r == 0) return 0;
      return (i_rs_id == r) || (i_uses_rt_id && i_rt_id == r);
   endfunction

   // Stall cycles demanded by the current inputs: the largest applicable rule.
   function automatic int need();
      int n = 0;
      if (i_branch_id && i_memRead_ex && reads(i_rd_ex)) n = 2;
      if (n < 1 && i_memRead_ex && reads(i_rd_ex)) n = 1;
      if (n < 1 && i_branch_id && i_regWrite_ex && reads(i_rd_ex)) n = 1;
      if (n < 1 && i_branch_id && i_memRead_ex_m && reads(i_rd_ex_m)) n = 1;
      return n;
   endfunction

   function automatic bit exp_stall();
      return (m_left > 0) || (need() != 0);
   endfunction

   // Model update on the active edge.
   always @(posedge i_clk) begin
      if (!i_rst_n) begin
         m_left  = 0;
         m_cnt   = 0;
         m_valid = 1;
      end else if (i_enable && m_valid) begin
         if (exp_stall() && m_cnt < (1 << NB_CNT) - 1) m_cnt = m_cnt + 1;
         if (m_left > 0) m_left = m_left - 1;
         else if (need() == 2) m_left = 1;
      end
   end

   // Compare every output against the model mid-cycle.
   always @(negedge i_clk) begin
      if (m_valid) begin
         check("stall_pc",     int'(o_stall_pc),     int'(exp_stall()));
         check("stall_if_id",  int'(o_stall_if_id),  int'(exp_stall()));
         check("bubble_id_ex", int'(o_bubble_id_ex), int'(exp_stall()));
         check("busy",         int'(o_busy),         int'(m_left > 0));
         check("stall_cycles", int'(o_stall_cycles), m_cnt);
      end
   end

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_in(input int rs, input int rt, input bit urt, input bit br,
                         input int rdx, input bit rw, input bit mr,
                         input int rdm, input bit mrm);
      i_rs_id        = rs[NB_ADDR-1:0];
      i_rt_id        = rt[NB_ADDR-1:0];
      i_uses_rt_id   = urt;
      i_branch_id    = br;
      i_rd_ex        = rdx[NB_ADDR-1:0];
      i_regWrite_ex  = rw;
      i_memRead_ex   = mr;
      i_rd_ex_m      = rdm[NB_ADDR-1:0];
      i_memRead_ex_m = mrm;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      idle();
      i_enable = 1'b1;
      i_rst_n  = 1'b0;
      cyc();
      i_rst_n  = 1'b1;
   endtask

   // Literal spot check of stall/busy/counter at the next negedge.
   task automatic lit(input string name, input int st, input int bz, input int cnt);
      @(negedge i_clk);
      check({name, ".stall"}, int'(o_stall_pc), st);
      check({name, ".busy"},  int'(o_busy),     bz);
      check({name, ".cnt"},   int'(o_stall_cycles), cnt);
   endtask

   initial begin
      i_rst_n  = 1'b0;
      i_enable = 1'b1;
      idle();

      // Reset state
      do_reset();
      lit("reset", 0, 0, 0);

      // Load-use: lw r5 in EX, add using r5 in ID -> one stall cycle
      cyc();
      set_in(5, 6, 1, 0, 5, 1, 1, 0, 0);
      lit("lu_c0", 1, 0, 0);
      cyc();
      idle();
      lit("lu_c1", 0, 0, 1);

      // Branch after load: two stall cycles, inputs dropped during STALL
      do_reset();
      set_in(3, 8, 1, 1, 8, 1, 1, 0, 0);
      lit("bl_c0", 1, 0, 0);
      cyc();
      idle();
      lit("bl_c1", 1, 1, 1);
      cyc();
      lit("bl_c2", 0, 0, 2);

      // Register zero never creates a dependency
      do_reset();
      set_in(0, 0, 1, 0, 0, 1, 1, 0, 0);
      lit("r0_load", 0, 0, 0);
      cyc();
      set_in(0, 0, 1, 1, 0, 1, 0, 0, 1);
      lit("r0_branch", 0, 0, 0);

      // Branch after ALU op -> 1 cycle; same dependency on non-branch -> none
      do_reset();
      set_in(4, 0, 0, 1, 4, 1, 0, 0, 0);
      lit("alu_br", 1, 0, 0);
      cyc();
      set_in(4, 0, 0, 0, 4, 1, 0, 0, 0);
      lit("alu_nobr", 0, 0, 1);

      // Branch on load result still in EX/MEM -> 1 cycle; rt ignored when unused
      cyc();
      set_in(1, 7, 1, 1, 0, 0, 0, 7, 1);
      lit("mem_br", 1, 0, 1);
      cyc();
      set_in(1, 7, 0, 1, 0, 0, 0, 7, 1);
      lit("mem_rt_unused", 0, 0, 2);
      cyc();
      set_in(7, 0, 0, 0, 0, 0, 0, 7, 1);
      lit("mem_nobr", 0, 0, 2);

      // Freeze while in STALL
      do_reset();
      set_in(8, 0, 0, 1, 8, 1, 1, 0, 0);
      lit("fz_c0", 1, 0, 0);
      cyc();
      idle();
      i_enable = 1'b0;
      lit("fz_c1", 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         lit("fz_hold", 1, 1, 1);
      end
      i_enable = 1'b1;
      cyc();
      lit("fz_end", 0, 0, 2);

      // Reset while in STALL
      do_reset();
      set_in(2, 9, 1, 1, 9, 1, 1, 0, 0);
      cyc();
      idle();
      lit("rs_busy", 1, 1, 1);
      i_rst_n = 1'b0;
      cyc();
      i_rst_n = 1'b1;
      lit("rs_after", 0, 0, 0);

      // Counter saturation on a persistent load-use hazard
      do_reset();
      set_in(6, 0, 0, 0, 6, 1, 1, 0, 0);
      for (int i = 0; i < 20; i++) cyc();
      lit("sat", 1, 0, (1 << NB_CNT) - 1);
      idle();
      cyc();
      lit("sat_idle", 0, 0, (1 << NB_CNT) - 1);

      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
